// File: rtl/phase_pkg.sv
// Shared types and helpers for the instruction-cycle phase sequencer.
package phase_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DEFAULT_N_PH = 5;
  localparam int MAX_PH       = 64;

  // Binary position of the set bit; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [MAX_PH-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_PH; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/phase_start_sync.sv
// Synchronises the asynchronous run request and turns its rising edge into a
// single-cycle start pulse.
module phase_start_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run_req,
  output logic start_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;

  // Clearing edge_reg in reset makes a request already high at release look new.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_reg <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], run_req};
      edge_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign start_pulse = sync_reg[SYNC_STAGES-1] & ~edge_reg;

endmodule

// File: rtl/phase_seq.sv
// One-hot instruction-cycle phase generator with stall hold, single-step pause
// and a completed-cycle counter.
module phase_seq
  import phase_pkg::*;
#(
  parameter int N_PH        = DEFAULT_N_PH,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    run_req,
  input  logic                    hlt,
  input  logic                    stall,
  input  logic                    step_mode,
  input  logic                    step,
  output logic [N_PH-1:0]         phase,
  output logic [$clog2(N_PH)-1:0] ph_idx,
  output logic                    running,
  output logic                    cycle_end,
  output logic [CNT_W-1:0]        cyc_cnt
);

  localparam int IDX_W = $clog2(N_PH);
  localparam logic [N_PH-1:0] FETCH = N_PH'(1);

  state_t            state_reg, state_next;
  logic [N_PH-1:0]   phase_reg, phase_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              start_pulse;

  phase_start_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_start_sync (
    .clk        (clk),
    .n_rst      (n_rst),
    .run_req    (run_req),
    .start_pulse(start_pulse)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        // A start coinciding with hlt is dropped; the edge flop has consumed it.
        if (!hlt && start_pulse) begin
          state_next = RUN;
          phase_next = FETCH;
        end
      end
      RUN: begin
        if (hlt) begin
          state_next = IDLE;
          phase_next = '0;
        end else if (!stall) begin
          if (phase_reg[N_PH-1]) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (step_mode) begin
              state_next = PAUSE;
              phase_next = '0;
            end else begin
              phase_next = FETCH;
            end
          end else begin
            phase_next = {phase_reg[N_PH-2:0], 1'b0};
          end
        end
      end
      PAUSE: begin
        if (hlt) begin
          state_next = IDLE;
        end else if (step || !step_mode) begin
          state_next = RUN;
          phase_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

  assign running   = (state_reg == RUN);
  assign phase     = phase_reg;
  assign ph_idx    = running ? IDX_W'(onehot_to_idx(MAX_PH'(phase_reg))) : '0;
  assign cycle_end = running & phase_reg[N_PH-1] & ~stall & ~hlt;
  assign cyc_cnt   = cnt_reg;

endmodule

// File: tb/tb_phase_seq.sv
// Self-checking bench for phase_seq: directed scenarios plus a randomized run
// against an index-based behavioural model.
module tb_phase_seq;

  localparam int N  = 5;
  localparam int S  = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst, run_req, hlt, stall, step_mode, step;
  logic [N-1:0]  phase;
  logic [2:0]    ph_idx;
  logic          running, cycle_end;
  logic [CW-1:0] cyc_cnt;

  logic          n_rst_b, run_req_b;
  logic          zero_b;
  logic [1:0]    phase_b;
  logic [0:0]    ph_idx_b;
  logic          running_b, cycle_end_b;
  logic [1:0]    cyc_cnt_b;

  int checks = 0;
  int errors = 0;

  phase_seq #(.N_PH(N), .SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .n_rst(n_rst), .run_req(run_req), .hlt(hlt), .stall(stall),
    .step_mode(step_mode), .step(step), .phase(phase), .ph_idx(ph_idx),
    .running(running), .cycle_end(cycle_end), .cyc_cnt(cyc_cnt)
  );

  phase_seq #(.N_PH(2), .SYNC_STAGES(2), .CNT_W(2)) dut_b (
    .clk(clk), .n_rst(n_rst_b), .run_req(run_req_b), .hlt(zero_b), .stall(zero_b),
    .step_mode(zero_b), .step(zero_b), .phase(phase_b), .ph_idx(ph_idx_b),
    .running(running_b), .cycle_end(cycle_end_b), .cyc_cnt(cyc_cnt_b)
  );

  // Reference model: mode 0 idle, 1 run, 2 pause; position kept as an integer.
  logic [S:0]    m_hist;
  int            m_mode, m_idx;
  logic [CW-1:0] m_cnt;
  wire           m_start = m_hist[S-1] & ~m_hist[S];

  always @(posedge clk) begin
    if (!n_rst) begin
      m_hist <= '0;
      m_mode <= 0;
      m_idx  <= 0;
      m_cnt  <= '0;
    end else begin
      m_hist <= {m_hist[S-1:0], run_req};
      case (m_mode)
        0: if (!hlt && m_start) begin m_mode <= 1; m_idx <= 0; end
        1: begin
          if (hlt) m_mode <= 0;
          else if (!stall) begin
            if (m_idx == N - 1) begin
              m_cnt  <= m_cnt + 1'b1;
              m_mode <= step_mode ? 2 : 1;
              m_idx  <= 0;
            end else begin
              m_idx <= m_idx + 1;
            end
          end
        end
        default: begin
          if (hlt) m_mode <= 0;
          else if (step || !step_mode) begin m_mode <= 1; m_idx <= 0; end
        end
      endcase
    end
  end

  logic [N-1:0] exp_phase;
  logic [2:0]   exp_idx;
  logic         exp_running, exp_cend;
  always_comb begin
    exp_phase   = '0;
    exp_idx     = '0;
    exp_running = (m_mode == 1);
    exp_cend    = (m_mode == 1) && (m_idx == N - 1) && !stall && !hlt;
    if (m_mode == 1) begin
      exp_phase = N'(1) << m_idx;
      exp_idx   = 3'(m_idx);
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [N-1:0] target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (phase == target) begin found = 1'b1; return; end
      edge1();
    end
    found = (phase == target);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; run_req = 1'b0; hlt = 1'b0; stall = 1'b0;
    step_mode = 1'b0; step = 1'b0;
    n_rst_b = 1'b0; run_req_b = 1'b0; zero_b = 1'b0;
    edge1();
    edge1();
    checks++;
    if ({phase, ph_idx, running, cycle_end, cyc_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got phase=%b idx=%0d run=%b cend=%b cnt=%0d want all zero",
               phase, ph_idx, running, cycle_end, cyc_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_start();
    logic [N-1:0] seq [0:4];
    seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    n_rst = 1'b1; run_req = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      edge1();
      checks++;
      if (phase !== '0) begin
        errors++; $display("FAIL start_latency edge %0d: phase=%b want 00000", e, phase);
      end
    end
    edge1();
    checks++;
    if (phase !== 5'b00001 || running !== 1'b1 || ph_idx !== 3'd0) begin
      errors++; $display("FAIL start_fetch: phase=%b run=%b idx=%0d want 00001 1 0", phase, running, ph_idx);
    end
    for (int i = 0; i < 5; i++) begin
      if (seq[i] == 5'b00001) begin
        edge1();
      end else begin
        edge1();
      end
      checks++;
      if (phase !== seq[i]) begin
        errors++; $display("FAIL rotate step %0d: phase=%b want %b", i, phase, seq[i]);
      end
      if (seq[i] == 5'b10000) begin
        checks++;
        if (cycle_end !== 1'b1 || ph_idx !== 3'd4) begin
          errors++; $display("FAIL last_phase: cend=%b idx=%0d want 1 4", cycle_end, ph_idx);
        end
      end
    end
    checks++;
    if (cyc_cnt !== 16'd1) begin
      errors++; $display("FAIL first_wrap_count: cnt=%0d want 1", cyc_cnt);
    end
    $display("test_start done");
  endtask

  task automatic test_stall();
    edge1();
    edge1();
    checks++;
    if (phase !== 5'b00100) begin errors++; $display("FAIL stall_setup: phase=%b want 00100", phase); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (phase !== 5'b00100) begin errors++; $display("FAIL stall_hold %0d: phase=%b want 00100", i, phase); end
    end
    stall = 1'b0;
    edge1();
    checks++;
    if (phase !== 5'b01000) begin errors++; $display("FAIL stall_release: phase=%b want 01000", phase); end
    edge1();
    stall = 1'b1;
    #1;
    checks++;
    if (phase !== 5'b10000 || cycle_end !== 1'b0) begin
      errors++; $display("FAIL stall_last: phase=%b cend=%b want 10000 0", phase, cycle_end);
    end
    for (int i = 0; i < 2; i++) begin
      edge1();
      checks++;
      if (phase !== 5'b10000 || cyc_cnt !== 16'd1) begin
        errors++; $display("FAIL stall_last_hold: phase=%b cnt=%0d want 10000 1", phase, cyc_cnt);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (cycle_end !== 1'b1) begin errors++; $display("FAIL stall_last_release: cend=%b want 1", cycle_end); end
    edge1();
    checks++;
    if (phase !== 5'b00001 || cyc_cnt !== 16'd2) begin
      errors++; $display("FAIL stall_wrap: phase=%b cnt=%0d want 00001 2", phase, cyc_cnt);
    end
    $display("test_stall done");
  endtask

  task automatic test_halt();
    bit found;
    run_to(5'b01000, found);
    checks++;
    if (!found) begin errors++; $display("FAIL halt_setup timeout: phase=%b want 01000", phase); end
    hlt = 1'b1;
    #1;
    checks++;
    if (cycle_end !== 1'b0) begin errors++; $display("FAIL halt_cend: cend=%b want 0", cycle_end); end
    edge1();
    hlt = 1'b0;
    checks++;
    if (phase !== '0 || running !== 1'b0 || cyc_cnt !== 16'd2) begin
      errors++; $display("FAIL halt_idle: phase=%b run=%b cnt=%0d want 0 0 2", phase, running, cyc_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      edge1();
      checks++;
      if (phase !== '0) begin errors++; $display("FAIL halt_no_restart %0d: phase=%b want 00000", i, phase); end
    end
    run_req = 1'b0;
    repeat (3) edge1();
    run_req = 1'b1;
    repeat (2) edge1();
    checks++;
    if (phase !== '0) begin errors++; $display("FAIL restart_early: phase=%b want 00000", phase); end
    edge1();
    checks++;
    if (phase !== 5'b00001 || cyc_cnt !== 16'd2) begin
      errors++; $display("FAIL restart: phase=%b cnt=%0d want 00001 2", phase, cyc_cnt);
    end
    $display("test_halt done");
  endtask

  task automatic test_step();
    bit found;
    step_mode = 1'b1;
    run_to(5'b10000, found);
    checks++;
    if (!found || cycle_end !== 1'b1) begin
      errors++; $display("FAIL step_last: found=%b cend=%b want 1 1", found, cycle_end);
    end
    edge1();
    checks++;
    if (phase !== '0 || running !== 1'b0 || cycle_end !== 1'b0 || cyc_cnt !== 16'd3) begin
      errors++; $display("FAIL step_pause: phase=%b run=%b cend=%b cnt=%0d want 0 0 0 3",
                         phase, running, cycle_end, cyc_cnt);
    end
    stall = 1'b1;
    repeat (3) edge1();
    stall = 1'b0;
    checks++;
    if (phase !== '0) begin errors++; $display("FAIL step_pause_hold: phase=%b want 00000", phase); end
    step = 1'b1;
    edge1();
    step = 1'b0;
    checks++;
    if (phase !== 5'b00001) begin errors++; $display("FAIL step_release: phase=%b want 00001", phase); end
    run_to(5'b10000, found);
    edge1();
    checks++;
    if (phase !== '0 || cyc_cnt !== 16'd4) begin
      errors++; $display("FAIL step_pause2: phase=%b cnt=%0d want 0 4", phase, cyc_cnt);
    end
    step_mode = 1'b0;
    edge1();
    checks++;
    if (phase !== 5'b00001 || running !== 1'b1) begin
      errors++; $display("FAIL step_mode_clear: phase=%b run=%b want 00001 1", phase, running);
    end
    $display("test_step done");
  endtask

  task automatic test_simultaneous();
    bit found;
    hlt = 1'b1;
    edge1();
    hlt = 1'b0;
    run_req = 1'b0;
    repeat (3) edge1();
    run_req = 1'b1;
    repeat (2) edge1();
    hlt = 1'b1;
    edge1();
    hlt = 1'b0;
    checks++;
    if (phase !== '0 || running !== 1'b0) begin
      errors++; $display("FAIL hlt_vs_start: phase=%b run=%b want 0 0", phase, running);
    end
    repeat (5) edge1();
    checks++;
    if (phase !== '0) begin errors++; $display("FAIL start_lost: phase=%b want 00000", phase); end
    run_req = 1'b0;
    repeat (3) edge1();
    run_req = 1'b1;
    run_to(5'b00100, found);
    checks++;
    if (!found || cyc_cnt === '0) begin
      errors++; $display("FAIL reset_setup: found=%b cnt=%0d want 1 nonzero", found, cyc_cnt);
    end
    n_rst = 1'b0;
    edge1();
    checks++;
    if ({phase, ph_idx, running, cycle_end, cyc_cnt} !== '0) begin
      errors++; $display("FAIL reset_mid_run: phase=%b idx=%0d run=%b cnt=%0d want all zero",
                         phase, ph_idx, running, cyc_cnt);
    end
    n_rst = 1'b1;
    $display("test_simultaneous done");
  endtask

  task automatic test_two_phase();
    logic [1:0] want_ph;
    logic [1:0] want_cnt;
    n_rst_b = 1'b1;
    run_req_b = 1'b1;
    repeat (2) edge1();
    checks++;
    if (phase_b !== 2'b00) begin errors++; $display("FAIL two_latency: phase=%b want 00", phase_b); end
    for (int k = 0; k <= 10; k++) begin
      edge1();
      want_ph  = (k % 2 == 0) ? 2'b01 : 2'b10;
      want_cnt = 2'((k / 2) % 4);
      checks++;
      if (phase_b !== want_ph || ph_idx_b !== 1'(k % 2) || cyc_cnt_b !== want_cnt
          || cycle_end_b !== (k % 2 == 1)) begin
        errors++; $display("FAIL two_phase k=%0d: phase=%b idx=%0d cnt=%0d cend=%b want %b %0d %0d %b",
                           k, phase_b, ph_idx_b, cyc_cnt_b, cycle_end_b, want_ph, k % 2, want_cnt, k % 2 == 1);
      end
    end
    $display("test_two_phase done");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) run_req = ~run_req;
      hlt   = ($urandom_range(15) == 0);
      stall = ($urandom_range(3) == 0);
      if ($urandom_range(9) == 0) step_mode = ~step_mode;
      step  = ($urandom_range(5) == 0);
      n_rst = ($urandom_range(99) != 0);
      #1;
      checks++;
      if (phase !== exp_phase || ph_idx !== exp_idx || running !== exp_running
          || cycle_end !== exp_cend || cyc_cnt !== m_cnt || !$onehot0(phase)) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d: phase=%b idx=%0d run=%b cend=%b cnt=%0d want %b %0d %b %b %0d",
                   i, phase, ph_idx, running, cycle_end, cyc_cnt,
                   exp_phase, exp_idx, exp_running, exp_cend, m_cnt);
      end
      edge1();
    end
    n_rst = 1'b1;
    $display("test_random done, cycles 500");
  endtask

  initial begin
    test_reset();
    test_start();
    test_stall();
    test_halt();
    test_step();
    test_simultaneous();
    test_two_phase();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/phase_seq.md
Name: phase_seq

Overview:
Parametrised successor to the five-phase instruction-cycle generator. It produces a one-hot phase vector of configurable length from a synchronised run request. It adds pipeline stall hold, a single-step mode and a completed-cycle counter. It sits between the front-panel/boot control and the processor datapath, which decodes its phase outputs.

Parameters:
N_PH, 5, number of phases per instruction cycle (>= 2); phase[0] is fetch.
SYNC_STAGES, 2, flops in the run_req synchroniser (>= 2).
CNT_W, 16, width of the completed-cycle counter.

Ports:
clk  in  1  clock, rising edge.
n_rst  in  1  synchronous active-low reset.
run_req  in  1  asynchronous run request; a rising edge starts sequencing.
hlt  in  1  synchronous halt (HLT instruction); returns the block to idle.
stall  in  1  holds the current phase while high.
step_mode  in  1  1 = pause after every completed cycle.
step  in  1  single-cycle pulse; releases one cycle while paused.
phase  out  N_PH  one-hot active phase; all-zero when idle or paused.
ph_idx  out  $clog2(N_PH)  binary index of the active phase; 0 when not running.
running  out  1  high in state RUN.
cycle_end  out  1  high when the last phase advances this cycle.
cyc_cnt  out  CNT_W  count of completed cycles.

Behaviour:
- Reset: the block is clocked only by clk, and n_rst is sampled on the clk edge. While n_rst=0 at an edge: state=IDLE, phase=0, ph_idx=0, running=0, cyc_cnt=0. All synchroniser and edge flops are cleared to 0.
- Start detect:
  - run_req passes through SYNC_STAGES flops, then one edge flop.
  - start_pulse = sync_out & ~edge_q.
  - If run_req is high from before edge 1, then phase[0]=1 after edge SYNC_STAGES+1 (edge 3 at the default).
  - Holding run_req high never generates a second start.
- States are IDLE, RUN and PAUSE. Priority at each edge is n_rst > hlt > start_pulse/step > stall > advance.
- IDLE:
  - start_pulse -> RUN with phase=1 (phase[0]).
  - All other inputs are ignored.
- RUN:
  - hlt -> IDLE with phase=0.
  - Otherwise stall=1 -> hold phase; cycle_end=0.
  - Otherwise rotate left, so phase[i] moves to phase[i+1].
  - In the last phase the rotation wraps: cycle_end=1 and cyc_cnt increments.
    - If step_mode=1 -> PAUSE with phase=0.
    - Otherwise -> phase[0] on the next edge.
  - start_pulse is ignored in RUN; there is no restart mid-cycle.
- PAUSE:
  - hlt -> IDLE.
  - step=1 or step_mode=0 -> RUN with phase[0].
  - stall is ignored.
- cycle_end is combinational from registered state: running & phase[N_PH-1] & ~stall & ~hlt.
- cyc_cnt:
  - Wraps modulo 2^CNT_W.
  - Cleared only by n_rst; hlt does not clear it.
- hlt and start_pulse in the same cycle: hlt wins and the start is lost. A new run_req rising edge is required.
- n_rst deasserting while run_req is already high is treated as a rising edge, so the block starts SYNC_STAGES+1 edges later.
- phase is always one-hot or zero; no other encoding is reachable.

Decomposition:
- Package phase_pkg holds:
  - the state enum {IDLE, RUN, PAUSE};
  - the default N_PH;
  - a function that converts one-hot to index.
- Sub-module phase_start_sync holds the SYNC_STAGES synchroniser plus edge flop, and outputs start_pulse.

Test Plan:
- Start: n_rst low for 2 cycles, then run_req=1 (N_PH=5) -> phase=00001 after edge 3. Then 00010, 00100, 01000, 10000, 00001. cycle_end is high in the 10000 cycle and cyc_cnt=1 after the wrap.
- Stall: stall=1 for 3 cycles while phase=00100 -> phase holds 00100 for 3 extra cycles, then goes to 01000. Stall while phase=10000 -> cycle_end=0 and cyc_cnt does not increment until released.
- Halt: hlt=1 while phase=01000 -> phase=0 and running=0. run_req held high -> no restart. Toggling run_req 0->1 restarts at phase 00001. cyc_cnt is unchanged by the halt.
- Single-step: step_mode=1 -> after 10000, phase=0 and state is PAUSE with cycle_end seen once. A step pulse -> 00001 on the next edge. Clearing step_mode in PAUSE resumes without a step.
- Simultaneous events: hlt together with start_pulse -> stays in IDLE. Reset mid-RUN (phase=00100) -> all outputs zero on the next edge, including cyc_cnt.
- Parameters: N_PH=2, CNT_W=2, five cycles -> phase alternates 01/10 and cyc_cnt wraps 3->0.
